riio_bias_seq: RTL and testbench

Power-up sequencer for the EG1.8V I/O ring bias. It enables the bias generator feeding the BIASPAD VBIAS net, waits a fixed settle time, then checks the bias-good indication. If bias is good, it enables the I/O banks one at a time, staggered, to limit inrush current. It also monitors bias continuously, force-disables all banks on bias loss, and performs an orderly staggered shutdown. The block sits in the always-on digital domain next to the pad ring.

---
 rtl/riio_bias_pkg.sv | 27 ++
 rtl/riio_bias_filter.sv | 59 +++++
 rtl/riio_bias_seq.sv | 179 +++++++++++++++++
 tb/tb_riio_bias_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riio_bias_pkg.sv
// Shared types and default parameters for the I/O ring bias sequencer.
// State encoding is visible on state_o, so the values are fixed.
package riio_bias_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RAMP     = 3'd2,
    ST_ON       = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } bias_state_e;

  localparam int unsigned DEF_NUM_BANKS      = 4;
  localparam int unsigned DEF_SETTLE_CYCLES  = 1024;
  localparam int unsigned DEF_STAGGER_CYCLES = 16;
  localparam int unsigned DEF_FILTER_CYCLES  = 8;

  // One spare bit so the saturating counter never reaches its limit in use.
  function automatic int unsigned cnt_width(input int unsigned settle,
                                            input int unsigned ramp);
    int unsigned m;
    m = (settle > ramp) ? settle : ramp;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/riio_bias_filter.sv
// Bias-good synchronizer with optional stability filter.
// Filter compiled in with RIIO_BIAS_SEQ_GLITCH_FILTER_EN.
module riio_bias_filter
  import riio_bias_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vbias_ok_i,
  output logic ok_o
);

  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("FILTER_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= vbias_ok_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RIIO_BIAS_SEQ_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [FW-1:0] r_cnt;
  logic          r_out;

  // r_cnt counts consecutive samples that disagree with the current output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (r_sync2 != r_out) begin
      if (r_cnt == FW'(FILTER_CYCLES - 1)) begin
        r_out <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign ok_o = r_out;
`else
  assign ok_o = r_sync2;
`endif

endmodule

// File: rtl/riio_bias_seq.sv
// Power-up/down sequencer for the EG1.8V I/O ring bias and staggered bank enables.
// Optional bias-good glitch filter: define RIIO_BIAS_SEQ_GLITCH_FILTER_EN.
//
// state    | meaning
// OFF      | bias and banks off, waiting for en_i
// SETTLE   | bias on, waiting SETTLE_CYCLES before checking bias-good
// RAMP     | enabling banks low to high, one per STAGGER_CYCLES
// ON       | all banks on, ready
// SHUTDOWN | disabling banks high to low, then bias off
// FAULT    | everything off, fault latched until fault_clr_i
module riio_bias_seq
  import riio_bias_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = DEF_NUM_BANKS,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 vbias_ok_i,
  input  logic                 fault_clr_i,
  output logic                 bias_en_o,
  output logic [NUM_BANKS-1:0] bank_en_o,
  output logic                 ready_o,
  output logic                 fault_o,
  output logic [2:0]           state_o
);

  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_bad_banks
    $error("NUM_BANKS must be in 1..16");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 2");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("STAGGER_CYCLES must be at least 1");
  end

  localparam int unsigned CW = cnt_width(SETTLE_CYCLES, STAGGER_CYCLES * NUM_BANKS);
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER   = CW'(STAGGER_CYCLES);

  logic w_ok;

  riio_bias_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .vbias_ok_i(vbias_ok_i),
    .ok_o      (w_ok)
  );

  bias_state_e          r_state, w_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_tgt, w_tgt;
  logic                 r_bias_en, w_bias_en;
  logic [NUM_BANKS-1:0] r_bank_en, w_bank_en;
  logic                 r_ready, w_ready;
  logic                 r_fault, w_fault;

  always_comb begin
    w_state   = r_state;
    w_tgt     = r_tgt;
    w_bias_en = r_bias_en;
    w_bank_en = r_bank_en;
    w_ready   = r_ready;
    w_fault   = r_fault;
    case (r_state)
      ST_OFF: begin
        if (en_i) begin
          w_state   = ST_SETTLE;
          w_bias_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!en_i) begin
          w_state   = ST_OFF;
          w_bias_en = 1'b0;
        end else if (r_cnt == SETTLE_TC) begin
          if (w_ok) begin
            w_state   = ST_RAMP;
            w_bank_en = NUM_BANKS'(1);
            w_tgt     = STAGGER - 1'b1;
          end else begin
            w_state   = ST_FAULT;
            w_bias_en = 1'b0;
            w_fault   = 1'b1;
          end
        end
      end
      ST_RAMP, ST_ON: begin
        if (!w_ok) begin
          w_state   = ST_FAULT;
          w_bias_en = 1'b0;
          w_bank_en = '0;
          w_ready   = 1'b0;
          w_fault   = 1'b1;
        end else if (!en_i) begin
          // The entry update already drops the highest enabled bank.
          w_state   = ST_SHUTDOWN;
          w_ready   = 1'b0;
          w_bank_en = r_bank_en >> 1;
          w_tgt     = STAGGER - 1'b1;
        end else if (r_state == ST_RAMP) begin
          if (&r_bank_en) begin
            w_state = ST_ON;
            w_ready = 1'b1;
          end else if (r_cnt == r_tgt) begin
            w_bank_en = (r_bank_en << 1) | NUM_BANKS'(1);
            w_tgt     = r_tgt + STAGGER;
          end
        end
      end
      ST_SHUTDOWN: begin
        if (!w_ok) begin
          w_state   = ST_FAULT;
          w_bias_en = 1'b0;
          w_bank_en = '0;
          w_fault   = 1'b1;
        end else if (r_cnt == r_tgt) begin
          if (|r_bank_en) begin
            w_bank_en = r_bank_en >> 1;
            w_tgt     = r_tgt + STAGGER;
          end else begin
            w_state   = ST_OFF;
            w_bias_en = 1'b0;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr_i) begin
          w_state = ST_OFF;
          w_fault = 1'b0;
        end
      end
      default: begin
        w_state   = ST_OFF;
        w_bias_en = 1'b0;
        w_bank_en = '0;
        w_ready   = 1'b0;
        w_fault   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_tgt     <= '0;
      r_bias_en <= 1'b0;
      r_bank_en <= '0;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tgt     <= w_tgt;
      r_bias_en <= w_bias_en;
      r_bank_en <= w_bank_en;
      r_ready   <= w_ready;
      r_fault   <= w_fault;
      if (w_state != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != {CW{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bias_en_o = r_bias_en;
  assign bank_en_o = r_bank_en;
  assign ready_o   = r_ready;
  assign fault_o   = r_fault;
  assign state_o   = r_state;

endmodule

// File: tb/tb_riio_bias_seq.sv
// Randomized bench for riio_bias_seq against a timing-arithmetic reference model.
module tb_riio_bias_seq;

  localparam int NB = 4;
  localparam int SC = 64;
  localparam int SG = 4;
  localparam int FC = 8;
`ifdef RIIO_BIAS_SEQ_GLITCH_FILTER_EN
  localparam int FD = FC;
`else
  localparam int FD = 0;
`endif

  localparam int P_OFF = 0, P_SETTLE = 1, P_RAMP = 2, P_ON = 3, P_SHUT = 4, P_FAULT = 5;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en = 1'b0;
  logic          vb = 1'b1;
  logic          clr = 1'b0;
  logic          bias_en;
  logic [NB-1:0] bank_en;
  logic          ready;
  logic          fault;
  logic [2:0]    state;

  int n_chk = 0;
  int n_fail = 0;

  riio_bias_seq #(
    .NUM_BANKS(NB), .SETTLE_CYCLES(SC), .STAGGER_CYCLES(SG), .FILTER_CYCLES(FC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .vbias_ok_i(vb), .fault_clr_i(clr),
    .bias_en_o(bias_en), .bank_en_o(bank_en), .ready_o(ready), .fault_o(fault),
    .state_o(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus the edge it was entered on; outputs derive from elapsed edges.
  int m_t = 0;
  int m_phase = P_OFF;
  int m_ts = 0;
  int m_n0 = 0;
  bit m_d1 = 0, m_d2 = 0, m_f = 0;
  bit m_hist[$];

  function automatic int banks_for(int ph, int kk);
    int n;
    n = 0;
    if (ph == P_RAMP) n = (kk / SG + 1 > NB) ? NB : kk / SG + 1;
    else if (ph == P_ON) n = NB;
    else if (ph == P_SHUT) n = (m_n0 - 1 - kk / SG < 0) ? 0 : m_n0 - 1 - kk / SG;
    return n;
  endfunction

  task automatic go(int ph);
    m_phase = ph;
    m_ts = m_t;
  endtask

  task automatic model_reset();
    m_phase = P_OFF;
    m_ts = m_t;
    m_d1 = 0; m_d2 = 0; m_f = 0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    bit ok;
    bit all_diff;
    int k;
    m_t++;
    ok = (FD > 0) ? m_f : m_d2;
    k = m_t - m_ts;
    case (m_phase)
      P_OFF:    if (en) go(P_SETTLE);
      P_SETTLE: if (!en) go(P_OFF); else if (k == SC) go(ok ? P_RAMP : P_FAULT);
      P_RAMP, P_ON: begin
        if (!ok) go(P_FAULT);
        else if (!en) begin
          m_n0 = banks_for(m_phase, k - 1);
          go(P_SHUT);
        end else if (m_phase == P_RAMP && k == (NB - 1) * SG + 1) go(P_ON);
      end
      P_SHUT:   if (!ok) go(P_FAULT); else if (k == m_n0 * SG) go(P_OFF);
      P_FAULT:  if (clr) go(P_OFF);
      default:  go(P_OFF);
    endcase
    if (FD > 0) begin
      m_hist.push_back(m_d2);
      if (m_hist.size() > FD) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == FD);
      foreach (m_hist[i]) if (m_hist[i] == m_f) all_diff = 0;
      if (all_diff) m_f = m_d2;
    end
    m_d2 = m_d1;
    m_d1 = vb;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
    end
  endtask

  task automatic check_outputs();
    int nb;
    nb = banks_for(m_phase, m_t - m_ts);
    chk("state", 32'(state), 32'(m_phase));
    chk("bias_en", 32'(bias_en),
        32'(m_phase == P_SETTLE || m_phase == P_RAMP || m_phase == P_ON || m_phase == P_SHUT));
    chk("bank_en", 32'(bank_en), 32'((1 << nb) - 1));
    chk("ready", 32'(ready), 32'(m_phase == P_ON));
    chk("fault", 32'(fault), 32'(m_phase == P_FAULT));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Called right after tick(): asserts reset between edges and releases before the next one.
  task automatic do_reset(bit directed);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check_outputs();
    if (directed) begin
      chk("rst_bank", 32'(bank_en), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
    end
    #2 rst_ni = 1'b1;
  endtask

  task automatic power_up();
    int n;
    vb = 1'b1;
    if (m_phase == P_FAULT) pulse_clr();
    en = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  initial begin
    int lat, n, off_at;
    #12;
    model_reset();
    check_outputs();
    rst_ni = 1'b1;

    // Clean power-up latency from OFF
    en = 1'b1;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 1) chk("bias_lat", 32'(bias_en), 32'd1);
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("pwrup_lat", 32'(lat), 32'(1 + SC + (NB - 1) * SG + 1));

    // Short glitch while ON
    run(5);
    vb = 1'b0;
    run(5);
    vb = 1'b1;
    run(20);
    chk("glitch5_state", 32'(state), (FD > 5) ? 32'(P_ON) : 32'(P_FAULT));

    // Longer glitch
    power_up();
    vb = 1'b0;
    run(9);
    vb = 1'b1;
    run(20);
    chk("glitch9_state", 32'(state), 32'(P_FAULT));

    // Sustained bias loss latency
    power_up();
    vb = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bank_en !== '0 && n < 60);
    chk("loss_lat", 32'(n), 32'(3 + FD));
    chk("loss_fault", 32'(fault), 32'd1);

    // No bias at the settle check
    pulse_clr();
    run(SC + 10);
    chk("nobias_fault", 32'(fault), 32'd1);
    chk("nobias_bias", 32'(bias_en), 32'd0);
    vb = 1'b1;
    en = 1'b0;
    run(12);
    pulse_clr();
    chk("clr_state", 32'(state), 32'(P_OFF));

    // Orderly shutdown with en re-raised midway
    power_up();
    en = 1'b0;
    off_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 7) en = 1'b1;
      tick();
      if (bias_en === 1'b0 && off_at == 0) off_at = i;
    end
    chk("shut_lat", 32'(off_at), 32'(NB * SG + 1));

    // Async reset in RAMP at bank_en=0011
    n = 0;
    while (bank_en !== 4'b0011 && n < 200) begin
      tick();
      n++;
    end
    chk("ramp_reach", 32'(bank_en), 32'd3);
    do_reset(1'b1);

    // Randomized traffic
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          en = ($urandom_range(0, 9) < 7);
          run($urandom_range(1, 120));
        end
        3, 4: begin
          vb = 1'b0;
          run($urandom_range(1, 12));
          vb = 1'b1;
          run($urandom_range(1, 20));
        end
        5: begin
          vb = 1'b0;
          run($urandom_range(20, 60));
          vb = 1'b1;
        end
        6, 7: pulse_clr();
        8: begin
          en = 1'b0;
          run($urandom_range(1, 25));
          en = 1'b1;
          run($urandom_range(1, 40));
        end
        default: begin
          run($urandom_range(1, 30));
          do_reset(1'b0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
